// File: rtl/sprite_arb_pkg.sv
// Shared types and defaults for the sprite draw arbiter.
// Optional build macro SPRITE_ARB_PRIO0_EN is consumed by sprite_draw_arbiter.
package sprite_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    DRAW    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int COORD_W_DEF     = 10;
  localparam int SEL_W_DEF       = 6;
  localparam int SPRITE_PIXELS   = 1024;
  localparam int ENG_LATENCY     = 2;
  localparam int DRAW_CYCLES_DEF = SPRITE_PIXELS + ENG_LATENCY;

endpackage

// File: rtl/sprite_draw_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or above ptr,
// otherwise the lowest eligible index overall.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [N-1:0] upper;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign upper[gi] = eligible[gi] & (ptr <= W'(gi));
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = W'(i);
        found  = 1'b1;
      end
    end
    // A hit in the upper window overrides the wrapped search.
    for (int i = N - 1; i >= 0; i--) begin
      if (upper[i]) winner = W'(i);
    end
  end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter sharing one draw_sprite engine among N_REQ sources, one draw per source per frame.
// Define SPRITE_ARB_PRIO0_EN to give source 0 fixed top priority over the rotating sources.
module sprite_draw_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int DRAW_CYCLES = DRAW_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_start,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*COORD_W-1:0] x_pos_in,
  input  logic [N_REQ*COORD_W-1:0] y_pos_in,
  input  logic [N_REQ*SEL_W-1:0]   sel_in,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     eng_plot,
  output logic [COORD_W-1:0]       eng_x_pos,
  output logic [COORD_W-1:0]       eng_y_pos,
  output logic [SEL_W-1:0]         eng_sel,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DRAW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAW_CYCLES - 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   served_q, served_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drew_any_q, drew_any_d;
  logic               eng_plot_q, eng_plot_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [COORD_W-1:0] eng_x_q, eng_x_d;
  logic [COORD_W-1:0] eng_y_q, eng_y_d;
  logic [SEL_W-1:0]   eng_sel_q, eng_sel_d;

  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   pick_elig;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               advance_ptr;

  assign eligible = req & ~served_q;

`ifdef SPRITE_ARB_PRIO0_EN
  assign pick_elig   = eligible & ~N_REQ'(1);
  assign win_idx     = eligible[0] ? '0 : pick_idx;
  assign win_any     = eligible[0] | pick_found;
  // Source 0 can only win through the override, so its wins leave the rotation alone.
  assign advance_ptr = (owner_q != '0);
`else
  assign pick_elig   = eligible;
  assign win_idx     = pick_idx;
  assign win_any     = pick_found;
  assign advance_ptr = 1'b1;
`endif

  rr_picker #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_rr_picker (
    .eligible (pick_elig),
    .ptr      (rr_ptr_q),
    .winner   (pick_idx),
    .found    (pick_found)
  );

  always_comb begin
    state_d      = state_q;
    served_d     = served_q;
    grant_d      = grant_q;
    done_d       = '0;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    drew_any_d   = drew_any_q;
    eng_plot_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    eng_x_d      = eng_x_q;
    eng_y_d      = eng_y_q;
    eng_sel_d    = eng_sel_q;

    case (state_q)
      IDLE: begin
        if (win_any) begin
          owner_d    = win_idx;
          grant_d    = N_REQ'(1) << win_idx;
          eng_x_d    = x_pos_in[win_idx*COORD_W +: COORD_W];
          eng_y_d    = y_pos_in[win_idx*COORD_W +: COORD_W];
          eng_sel_d  = sel_in[win_idx*SEL_W +: SEL_W];
          eng_plot_d = 1'b1;
          busy_d     = 1'b1;
          // Counter is live during the plot cycle so done lands DRAW_CYCLES after plot.
          cnt_d      = CNT_LOAD;
          state_d    = LAUNCH;
        end else if (drew_any_q) begin
          frame_done_d = 1'b1;
          drew_any_d   = 1'b0;
        end
      end
      LAUNCH: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = DRAW;
      end
      DRAW: begin
        if (cnt_q == '0) begin
          done_d  = N_REQ'(1) << owner_q;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        served_d[owner_q] = 1'b1;
        if (advance_ptr) begin
          rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        end
        drew_any_d = 1'b1;
        grant_d    = '0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) begin
      served_d   = '0;
      drew_any_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      served_q     <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      drew_any_q   <= 1'b0;
      eng_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      eng_x_q      <= '0;
      eng_y_q      <= '0;
      eng_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      served_q     <= served_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      drew_any_q   <= drew_any_d;
      eng_plot_q   <= eng_plot_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      eng_x_q      <= eng_x_d;
      eng_y_q      <= eng_y_d;
      eng_sel_q    <= eng_sel_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign eng_plot   = eng_plot_q;
  assign eng_x_pos  = eng_x_q;
  assign eng_y_pos  = eng_y_q;
  assign eng_sel    = eng_sel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Scoreboard bench for sprite_draw_arbiter: stimulus queues expected plot/done/frame_done
// events, an independent negedge monitor pops and compares them as the DUT emits them.
module tb_sprite_draw_arbiter;

  localparam int N   = 4;
  localparam int CW  = 10;
  localparam int SW  = 6;
  localparam int DC  = 1026;
  localparam int CLK = 10;

  localparam int K_PLOT = 0;
  localparam int K_DONE = 1;
  localparam int K_FD   = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_start;
  logic [N-1:0]  req;
  logic [N*CW-1:0] x_pos_in, y_pos_in;
  logic [N*SW-1:0] sel_in;
  logic [N-1:0]  grant, done;
  logic          eng_plot, busy, frame_done;
  logic [CW-1:0] eng_x_pos, eng_y_pos;
  logic [SW-1:0] eng_sel;

  logic [CW-1:0] xs [N];
  logic [CW-1:0] ys [N];
  logic [SW-1:0] sels [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_pos_in[i*CW +: CW] = xs[i];
      y_pos_in[i*CW +: CW] = ys[i];
      sel_in[i*SW +: SW]   = sels[i];
    end
  end

  sprite_draw_arbiter #(
    .N_REQ(N), .COORD_W(CW), .SEL_W(SW), .DRAW_CYCLES(DC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .req(req),
    .x_pos_in(x_pos_in), .y_pos_in(y_pos_in), .sel_in(sel_in),
    .grant(grant), .done(done), .eng_plot(eng_plot),
    .eng_x_pos(eng_x_pos), .eng_y_pos(eng_y_pos), .eng_sel(eng_sel),
    .busy(busy), .frame_done(frame_done)
  );

  always #(CLK/2) clk = ~clk;

  typedef struct {
    int            kind;
    logic [N-1:0]  vec;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [SW-1:0] sel;
  } exp_t;

  exp_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   plot_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req_v, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  function automatic exp_t mk(input int kind, input int src);
    exp_t e;
    e.kind = kind;
    e.vec  = (kind == K_FD) ? '0 : N'(1) << src;
    e.x    = xs[src];
    e.y    = ys[src];
    e.sel  = sels[src];
    return e;
  endfunction

  task automatic push(input int kind, input int src);
    sb.push_back(mk(kind, src));
  endtask

  task automatic handle(input int kind, input logic [N-1:0] vec);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d vec 0x%0h, expected none (cycle %0d)", kind, vec, cyc);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind != K_FD) begin
      chk(kind == K_PLOT ? "grant" : "done", vec, e.vec);
      chk("eng_x", eng_x_pos, e.x);
      chk("eng_y", eng_y_pos, e.y);
      chk("eng_sel", eng_sel, e.sel);
      chk("busy", busy, 1);
    end
    if (kind == K_PLOT) plot_cyc = cyc;
    if (kind == K_DONE) chk("plot_to_done", cyc - plot_cyc, DC);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (eng_plot)   handle(K_PLOT, grant);
      if (|done)      handle(K_DONE, done);
      if (frame_done) handle(K_FD, '0);
    end
  end

  task automatic wait_done(input int i);
    int n = 0;
    while (!done[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done[i]) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_done%0d: got timeout, expected done pulse", i);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    #(CLK * 100000);
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    req         = 4'b1111;
    for (int i = 0; i < N; i++) begin
      xs[i]   = CW'(16 * i + 1);
      ys[i]   = CW'(8 * i + 2);
      sels[i] = SW'(i + 1);
    end
    repeat (4) @(negedge clk);

    // Reset: all outputs quiet while held.
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", eng_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_eng_x", eng_x_pos, 0);
    chk("rst_eng_y", eng_y_pos, 0);
    chk("rst_eng_sel", eng_sel, 0);

    // First grant after release goes to source 0, plot one cycle on.
    push(K_PLOT, 0); push(K_DONE, 0); push(K_FD, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_plot", eng_plot, 1);
    wait_done(0);
    req = 4'b0000;
    drain(100);

    // Round-robin order 0,1,3 from a fresh reset, then one frame_done.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push(K_PLOT, 0); push(K_DONE, 0);
    push(K_PLOT, 1); push(K_DONE, 1);
    push(K_PLOT, 3); push(K_DONE, 3);
    push(K_FD, 0);
    req = 4'b1011;
    pulse_fs();
    drain(5000);

    // Served source is not re-granted until a new frame opens.
    req = 4'b0001;
    repeat (50) @(negedge clk);
    chk("no_grant_before_fs", grant, 0);
    push(K_PLOT, 0); push(K_DONE, 0); push(K_FD, 0);
    pulse_fs();
    drain(2000);

    // Latched coordinates survive an input change mid-draw.
    xs[2] = 10'd100; ys[2] = 10'd50; sels[2] = 6'h05;
    push(K_PLOT, 2); push(K_DONE, 2); push(K_FD, 0);
    req = 4'b0100;
    repeat (100) @(negedge clk);
    xs[2] = 10'd300;
    @(negedge clk);
    chk("latch_x_mid", eng_x_pos, 100);
    sb[1].x = 10'd100;
    drain(2000);

    // frame_start landing on RELEASE: the same source is served again.
    req = 4'b0010;
    push(K_PLOT, 1); push(K_DONE, 1);
    push(K_PLOT, 1); push(K_DONE, 1);
    push(K_FD, 0);
    wait_done(1);
    pulse_fs();
    drain(3000);

    // Sources 0 and 3 rise while 2 is drawing.
    req = 4'b0000;
    pulse_fs();
    push(K_PLOT, 2); push(K_DONE, 2);
`ifdef SPRITE_ARB_PRIO0_EN
    push(K_PLOT, 0); push(K_DONE, 0);
    push(K_PLOT, 3); push(K_DONE, 3);
`else
    push(K_PLOT, 3); push(K_DONE, 3);
    push(K_PLOT, 0); push(K_DONE, 0);
`endif
    push(K_FD, 0);
    req = 4'b0100;
    repeat (50) @(negedge clk);
    req = 4'b1101;
    drain(4000);

    repeat (20) @(negedge clk);
    chk("final_idle_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
